// File: rtl/input_conditioner.sv
// Board-pin conditioner: 2-flop synchroniser, shared sample-tick prescaler and
// per-bit debounce counters producing clean BUTTONS levels plus change strobes.
module input_conditioner #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      TICK_DIV     = 4000,
    parameter int unsigned      STABLE_TICKS = 8,
    parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b1}}
) (
    input  logic             CLK_4M,
    input  logic             nRESET,
    input  logic [WIDTH-1:0] RAW,
    output logic [WIDTH-1:0] BUTTONS,
    output logic [WIDTH-1:0] CHANGED,
    output logic             TICK
);

    localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned   CW        = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] buttons_q, buttons_d;
    logic [WIDTH-1:0] changed_q, changed_d;
    logic             tick_q, tick_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Prescaler free-runs; TICK is registered so it lands the cycle after the wrap value.
    always_comb begin
        tick_d  = (presc_q == PRESC_MAX);
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end

    always_comb begin
        buttons_d = buttons_q;
        changed_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == buttons_q[i]) begin
                // Any return to the accepted level abandons the pending change.
                cnt_d[i] = '0;
            end else if (tick_q) begin
                if (cnt_q[i] == CNT_MAX) begin
                    buttons_d[i] = sync2_q[i];
                    changed_d[i] = 1'b1;
                    cnt_d[i]     = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK_4M) begin
        if (!nRESET) begin
            sync1_q   <= RESET_VAL;
            sync2_q   <= RESET_VAL;
            buttons_q <= RESET_VAL;
            changed_q <= '0;
            tick_q    <= 1'b0;
            presc_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= RAW;
            sync2_q   <= sync1_q;
            buttons_q <= buttons_d;
            changed_q <= changed_d;
            tick_q    <= tick_d;
            presc_q   <= presc_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign BUTTONS = buttons_q;
    assign CHANGED = changed_q;
    assign TICK    = tick_q;

endmodule
